// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions.
// Word width, bubble encoding, FSM states and queue entry layout.
package fetch_unit_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small synchronous FIFO holding prefetched {instr, npc} entries.
// Flush wins over a same-cycle push.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [2*DATA_W-1:0]     din,
  output logic [2*DATA_W-1:0]     head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= din;
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rdPtr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction
// memory, buffers words and feeds decode through a registered output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [DATA_W-1:0] TruePC,
  output logic              IMemReq,
  output logic [DATA_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [DATA_W-1:0] IMemData,
  output logic [DATA_W-1:0] Instruct,
  output logic [DATA_W-1:0] NextPC,
  output logic              InstValid
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t state;
  fetch_state_t stateNext;

  logic [DATA_W-1:0] fetchPC;
  logic [DATA_W-1:0] fetchPCNext;
  logic [DATA_W-1:0] addrNext;
  logic              reqNext;

  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic          empty;
  logic          full;
  logic          flush;
  logic          push;
  logic          pop;

  fetch_entry_t        pushEntry;
  fetch_entry_t        headEntry;
  logic [2*DATA_W-1:0] headRaw;

  assign flush = Redirect && !Stall;
  assign pop   = !Stall && !Redirect && !empty;
  assign push  = (state == WAIT) && IMemAck && !flush;

  assign pushEntry = '{instr: IMemData, npc: IMemAddr + 1'b1};
  assign headEntry = fetch_entry_t'(headRaw);
  assign countNext = count + CW'(push) - CW'(pop);

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (pushEntry),
    .head (headRaw),
    .count(count),
    .empty(empty),
    .full (full)
  );

  always_comb begin
    stateNext   = state;
    fetchPCNext = fetchPC;
    reqNext     = IMemReq;
    addrNext    = IMemAddr;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetchPCNext = TruePC;
        end else if (!full) begin
          stateNext = WAIT;
          reqNext   = 1'b1;
          addrNext  = fetchPC;
        end
      end
      WAIT: begin
        if (flush) begin
          fetchPCNext = TruePC;
          if (IMemAck) begin
            stateNext = IDLE;
            reqNext   = 1'b0;
          end else begin
            stateNext = DISCARD;
          end
        end else if (IMemAck) begin
          fetchPCNext = fetchPC + 1'b1;
          if (countNext < CW'(BUF_DEPTH)) begin
            addrNext = fetchPC + 1'b1;
          end else begin
            stateNext = IDLE;
            reqNext   = 1'b0;
          end
        end
      end
      DISCARD: begin
        // The in-flight word belongs to the abandoned path.
        if (flush) fetchPCNext = TruePC;
        if (IMemAck) begin
          if (!flush && countNext < CW'(BUF_DEPTH)) begin
            stateNext = WAIT;
            addrNext  = fetchPC;
          end else begin
            stateNext = IDLE;
            reqNext   = 1'b0;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetchPC  <= RESET_PC;
      IMemReq  <= 1'b0;
      IMemAddr <= RESET_PC;
    end else begin
      state    <= stateNext;
      fetchPC  <= fetchPCNext;
      IMemReq  <= reqNext;
      IMemAddr <= addrNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Instruct  <= NOP_INSTR;
      NextPC    <= RESET_PC;
      InstValid <= 1'b0;
    end else if (!Stall) begin
      if (Redirect) begin
        Instruct  <= NOP_INSTR;
        NextPC    <= TruePC;
        InstValid <= 1'b0;
      end else if (!empty) begin
        Instruct  <= headEntry.instr;
        NextPC    <= headEntry.npc;
        InstValid <= 1'b1;
      end else begin
        Instruct  <= NOP_INSTR;
        InstValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency memory, expected instruction
// stream per redirect/reset, monitor compares each delivered word.
module tb_fetch_unit;

  localparam logic [15:0] RPC = 16'hFFFE;
  localparam logic [15:0] KEY = 16'hA000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] TruePC = '0;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [15:0] IMemData;
  logic [15:0] Instruct;
  logic [15:0] NextPC;
  logic        InstValid;

  int checks = 0;
  int errors = 0;
  int minLat = 0;
  int maxLat = 0;

  logic [31:0] expQ [$];

  always #5 clk = ~clk;

  assign IMemData = IMemAddr ^ KEY;

  fetch_unit #(
    .RESET_PC (RPC),
    .BUF_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Stall    (Stall),
    .Redirect (Redirect),
    .TruePC   (TruePC),
    .IMemReq  (IMemReq),
    .IMemAddr (IMemAddr),
    .IMemAck  (IMemAck),
    .IMemData (IMemData),
    .Instruct (Instruct),
    .NextPC   (NextPC),
    .InstValid(InstValid)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Program order from pc: word at a is a^KEY, its NextPC is a+1.
  task automatic loadStream(input logic [15:0] pc);
    logic [15:0] a;
    expQ.delete();
    for (int i = 0; i < 64; i++) begin
      a = pc + 16'(i);
      expQ.push_back({a ^ KEY, 16'(a + 16'd1)});
    end
  endtask

  // Memory model: ack after a random latency, one word per request.
  int          age = 0;
  int          lat = 0;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic [15:0] prevAddr = '0;

  always @(negedge clk) begin
    if (prevReq && IMemReq && !prevAck)
      check("addrStable", IMemAddr, prevAddr);
    if (!IMemReq) begin
      IMemAck = 1'b0;
      age = 0;
    end else begin
      if (!prevReq || prevAck) begin
        age = 0;
        lat = $urandom_range(maxLat, minLat);
      end
      IMemAck = (age >= lat);
      age++;
    end
    prevReq  = IMemReq;
    prevAck  = IMemAck;
    prevAddr = IMemAddr;
  end

  // Monitor
  logic        started = 1'b0;
  logic        sRst, sStall, sRed;
  logic [15:0] sTpc;
  logic [15:0] pInst, pNpc;
  logic        pVal;
  logic [31:0] expv;

  always @(posedge clk) begin
    sRst   = rst;
    sStall = Stall;
    sRed   = Redirect;
    sTpc   = TruePC;
    #1;
    if (sRst) begin
      check("rstValid", InstValid, 0);
      check("rstInstr", Instruct, 0);
      check("rstNpc", NextPC, RPC);
      check("rstReq", IMemReq, 0);
      check("rstAddr", IMemAddr, RPC);
      started = 1'b1;
    end else if (started) begin
      if (sStall) begin
        check("holdInstr", Instruct, pInst);
        check("holdNpc", NextPC, pNpc);
        check("holdValid", InstValid, pVal);
      end else if (sRed) begin
        check("redirValid", InstValid, 0);
        check("redirInstr", Instruct, 0);
        check("redirNpc", NextPC, sTpc);
      end else if (InstValid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL stream actual %h required none", {Instruct, NextPC});
        end else begin
          expv = expQ.pop_front();
          if ({Instruct, NextPC} !== expv) begin
            errors++;
            $display("FAIL stream actual %h required %h",
                     {Instruct, NextPC}, expv);
          end
        end
      end else begin
        check("bubbleInstr", Instruct, 0);
        check("bubbleNpc", NextPC, pNpc);
      end
    end
    pInst = Instruct;
    pNpc  = NextPC;
    pVal  = InstValid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    Redirect = 1'b0;
    loadStream(RPC);
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    Redirect = 1'b1;
    TruePC = pc;
    if (!Stall) loadStream(pc);
    step();
    Redirect = 1'b0;
  endtask

  task automatic waitReq(input logic wantAck);
    int n = 0;
    while (!(IMemReq && IMemAck == wantAck) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL waitReq actual timeout required ack=%0b", wantAck);
    end
  endtask

  logic [15:0] hI, hN;
  logic        hV;
  int          since;
  int          r;

  initial begin
    // Reset release with 1-cycle memory, wrap at 16'hFFFF
    minLat = 0;
    maxLat = 0;
    doReset(2);
    @(posedge clk); #2;
    check("e1Valid", InstValid, 0);
    check("e1Req", IMemReq, 1);
    check("e1Addr", IMemAddr, RPC);
    @(posedge clk); #2;
    check("e2Valid", InstValid, 0);
    @(posedge clk); #2;
    check("e3Valid", InstValid, 1);
    check("e3Instr", Instruct, RPC ^ KEY);
    check("e3Npc", NextPC, 16'hFFFF);
    @(posedge clk); #2;
    check("e4Instr", Instruct, 16'hFFFF ^ KEY);
    check("e4Npc", NextPC, 16'h0000);
    @(posedge clk); #2;
    check("e5Instr", Instruct, 16'h0000 ^ KEY);
    check("e5Npc", NextPC, 16'h0001);
    step();

    // Stall holds output, queue fills and requests stop
    Stall = 1'b1;
    hI = Instruct;
    hN = NextPC;
    hV = InstValid;
    repeat (5) step();
    check("stallInstr", Instruct, hI);
    check("stallNpc", NextPC, hN);
    check("stallValid", InstValid, hV);
    check("stallReqDrop", IMemReq, 0);
    Stall = 1'b0;
    @(posedge clk); #2;
    check("rel1Valid", InstValid, 1);
    @(posedge clk); #2;
    check("rel2Valid", InstValid, 1);
    step();

    // Redirect while an ack is pending
    minLat = 3;
    maxLat = 3;
    waitReq(1'b0);
    redirect(16'h0040);
    waitReq(1'b1);
    step();
    check("discReq", IMemReq, 1);
    check("discAddr", IMemAddr, 16'h0040);
    repeat (6) step();

    // Redirect in the same cycle as an ack
    minLat = 0;
    maxLat = 1;
    waitReq(1'b1);
    redirect(16'h1234);
    check("sameReqLow", IMemReq, 0);
    step();
    check("sameReq", IMemReq, 1);
    check("sameAddr", IMemAddr, 16'h1234);
    repeat (4) step();

    // Reset during a pending request with decode stalled
    minLat = 2;
    maxLat = 2;
    Stall = 1'b1;
    waitReq(1'b0);
    doReset(1);
    Stall = 1'b0;
    repeat (3) step();

    // Random traffic
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        minLat = 0;
        maxLat = (c / 500) % 4;
      end
      r = $urandom_range(99, 0);
      Stall = ($urandom_range(3, 0) == 0) && (since < 40);
      Redirect = 1'b0;
      rst = 1'b0;
      if (r < 2) begin
        rst = 1'b1;
        loadStream(RPC);
        since = 0;
      end else if (r < 8 || since >= 40) begin
        Redirect = 1'b1;
        TruePC = 16'($urandom);
        if (!Stall) begin
          loadStream(TruePC);
          since = 0;
        end
      end
      since++;
      step();
    end
    rst = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit pipeline. It is the producer end of the decode interface: it supplies Instruct/NextPC to decode and consumes decode's TruePC/redirect back.
- Owns the fetch PC.
- Drives a variable-latency instruction-memory req/ack handshake.
- Buffers fetched words in a 2-entry queue.
- Holds its output register while decode is stalled.
- Flushes cleanly on a taken branch or jump.

Parameters:
DATA_W, 16, instruction and address width
RESET_PC, 16'h0000, fetch PC after reset
BUF_DEPTH, 2, prefetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
Stall  in  1  decode stalled; hold outputs
Redirect  in  1  decode took branch/jump (BranchFlag|Jump)
TruePC  in  16  redirect target, valid with Redirect
IMemReq  out  1  instruction-memory request
IMemAddr  out  16  word address; stable while IMemReq=1
IMemAck  in  1  data valid this cycle, ends the request
IMemData  in  16  instruction word, valid with IMemAck
Instruct  out  16  instruction to decode (registered)
NextPC  out  16  PC of Instruct + 1 (registered)
InstValid  out  1  Instruct is real; 0 = bubble carrying NOP_INSTR

Behaviour:
- Reset (synchronous, active-high, clk): FetchPC=RESET_PC; IMemReq=0; IMemAddr=RESET_PC; queue empty; state=IDLE; Instruct=NOP_INSTR; NextPC=RESET_PC; InstValid=0. rst mid-request abandons the request; memory must tolerate IMemReq dropping without an ack.
- Addressing: word-addressed. Each fetched entry stores {IMemData, IMemAddr+1}. Adds are mod 2^16, so 16'hFFFF wraps to 16'h0000.
- At most one outstanding request. IMemReq and IMemAddr are registered.
- FSM:
  - IDLE: if count<BUF_DEPTH -> WAIT, IMemReq<=1, IMemAddr<=FetchPC.
  - WAIT, on IMemAck: push the entry and set FetchPC<=FetchPC+1. If count after push and pop < BUF_DEPTH, stay WAIT with IMemAddr<=FetchPC+1. Otherwise go IDLE with IMemReq<=0.
  - DISCARD: IMemReq stays 1 with the old IMemAddr. On IMemAck, drop the data, then go IDLE, or directly WAIT with IMemAddr<=FetchPC.
- An ack never overflows the queue because a request only starts when count<BUF_DEPTH.
- Memory latency: ack arrives >=1 cycle after IMemReq first seen high. Ack in the same cycle as the req rise is illegal.
- Output register, when !Stall and !Redirect:
  - Queue non-empty: pop the head into Instruct/NextPC and set InstValid<=1.
  - Queue empty: Instruct<=NOP_INSTR, InstValid<=0, NextPC unchanged.
- Stall=1: Instruct, NextPC, InstValid and the queue head are held. Fetching into free queue slots continues.
- Redirect, honoured only when Stall=0:
  - Flush the queue.
  - Next cycle: Instruct=NOP_INSTR, InstValid=0, NextPC=TruePC.
  - FetchPC<=TruePC.
  - If in WAIT with no ack this cycle -> DISCARD.
  - If an ack arrives the same cycle, drop it and start a fetch of TruePC next cycle.
  - In IDLE, start a fetch of TruePC next cycle.
- Redirect while Stall=1 is ignored; decode re-presents it.
- Priority: rst > Redirect > pop; push+pop in the same cycle is legal at any count.
- Latency: no bypass from IMemData to Instruct. Best-case redirect-to-valid is 4 cycles:
  - edge 1: flush;
  - edge 2: req high;
  - edge 3: ack/push;
  - edge 4: pop.

Decomposition:
- Shared cpu_defs package/include: NOP_INSTR (16'h0000), FSM state encodings IDLE/WAIT/DISCARD, DATA_W.
- Sub-module fetch_buffer: BUF_DEPTH-entry sync FIFO of {instr[15:0], npc[15:0]}.
  - Inputs: push, pop, flush.
  - Outputs: count, head, empty, full.
  - Flush takes priority over push.

Test Plan:
- Reset release, 1-cycle memory, IMemData=addr^16'hA000 -> IMemAddr 0,1,2,... back-to-back; first InstValid=1 on 3rd edge after rst release with Instruct=16'hA000, NextPC=1, then one instruction per cycle.
- Stall held 5 cycles at Instruct=16'hA002 -> outputs constant; queue fills to 2 and IMemReq drops; after release, A003, A004 are delivered on consecutive cycles with no bubble.
- Redirect, TruePC=16'h0040, while WAIT and ack pending 3 cycles -> next cycle InstValid=0, NextPC=16'h0040; old ack data dropped; next IMemAddr=16'h0040; first valid Instruct is from address 0x40.
- Redirect and IMemAck in the same cycle -> acked word never appears at Instruct; next request address equals TruePC.
- RESET_PC=16'hFFFE -> Instruct from FFFE, FFFF, 0000 with NextPC FFFF, 0000, 0001.
- rst asserted mid-WAIT with Stall=1 -> next cycle all outputs at reset values and IMemReq=0; fetch restarts at RESET_PC.
